// File: rtl/adc_lane_align.sv
// Per-lane ADC deserialiser alignment: delay-tap eye scan, eye centring, then bitslip to the training word.
// Latency: about (MAXTAP+1)*(INC_GAP+SETTLE+NCHK) cycles per lane for the scan, plus seek and slip phases.
// No backpressure: START is honoured only when idle; DINC/DRST/BS are fire-and-forget one-cycle pulses.
module adc_lane_align #(
    parameter int             NLANES  = 16,
    parameter int             W       = 6,
    parameter logic [W-1:0]   PATTERN = 6'b111000,
    parameter int             MAXTAP  = 63,
    parameter int             SETTLE  = 16,
    parameter int             NCHK    = 32,
    parameter int             INC_GAP = 4,
    parameter int             MINWIN  = 4,
    localparam int            LW      = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [NLANES*W-1:0]   DIN,
    output logic [NLANES-1:0]     DINC,
    output logic [NLANES-1:0]     DRST,
    output logic [NLANES-1:0]     BS,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [NLANES-1:0]     LOCKED,
    output logic [LW-1:0]         CUR_LANE
);

    // Tap counter carries one extra bit so tap and window lengths up to MAXTAP+1 never wrap.
    localparam int TW   = $clog2(MAXTAP + 1) + 1;
    localparam int CMAX = (SETTLE > NCHK) ? ((SETTLE > INC_GAP) ? SETTLE : INC_GAP)
                                          : ((NCHK > INC_GAP) ? NCHK : INC_GAP);
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = (W > 1) ? $clog2(W) : 1;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_LRST        = 4'd1;
    localparam logic [3:0] S_SETTLE      = 4'd2;
    localparam logic [3:0] S_CHECK       = 4'd3;
    localparam logic [3:0] S_STEP        = 4'd4;
    localparam logic [3:0] S_CENTRE      = 4'd5;
    localparam logic [3:0] S_SEEK        = 4'd6;
    localparam logic [3:0] S_SLIP_SETTLE = 4'd7;
    localparam logic [3:0] S_SLIP_CHK    = 4'd8;
    localparam logic [3:0] S_NEXT        = 4'd9;
    localparam logic [3:0] S_FINISH      = 4'd10;

    logic [3:0]        state;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tap;
    logic [TW-1:0]     target;
    logic [TW-1:0]     cur_len;
    logic [TW-1:0]     cur_start;
    logic [TW-1:0]     best_len;
    logic [TW-1:0]     best_start;
    logic [SW-1:0]     slip;
    logic [W-1:0]      ref_word;
    logic              chk_ok;

    logic [W-1:0]      lane_word;
    logic [NLANES-1:0] lane_bit;
    logic              good_now;
    logic              pat_now;
    logic [TW-1:0]     new_cur_len;
    logic [TW-1:0]     new_cur_start;

    // Only the lane under training is observed; its command pulses go to the same bit.
    assign lane_word = DIN[int'(CUR_LANE)*W +: W];
    assign lane_bit  = NLANES'(1) << CUR_LANE;

    // Running stability/pattern verdicts including the current sample, and the window update they imply.
    always_comb begin
        good_now      = chk_ok && (lane_word == ref_word);
        pat_now       = chk_ok && (lane_word == PATTERN);
        new_cur_len   = good_now ? (cur_len + TW'(1)) : '0;
        new_cur_start = (good_now && (cur_len == '0)) ? tap : cur_start;
    end

    // Training sequencer: pulses default low every cycle so each command is exactly one cycle wide.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tap        <= '0;
            target     <= '0;
            cur_len    <= '0;
            cur_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            slip       <= '0;
            ref_word   <= '0;
            chk_ok     <= 1'b0;
            DINC       <= '0;
            DRST       <= '0;
            BS         <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            LOCKED     <= '0;
            CUR_LANE   <= '0;
        end else begin
            DINC <= '0;
            DRST <= '0;
            BS   <= '0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                        LOCKED   <= '0;
                        CUR_LANE <= '0;
                        state    <= S_LRST;
                    end
                end

                // Return the delay line to tap 0 and forget any window from the previous lane.
                S_LRST: begin
                    DRST       <= lane_bit;
                    tap        <= '0;
                    best_len   <= '0;
                    best_start <= '0;
                    cur_len    <= '0;
                    cur_start  <= '0;
                    cnt        <= '0;
                    state      <= S_SETTLE;
                end

                // Let the delay settle, then take the reference word for this tap.
                S_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        ref_word <= lane_word;
                        chk_ok   <= 1'b1;
                        cnt      <= '0;
                        state    <= S_CHECK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // A tap is good only if every one of NCHK samples equals the reference.
                S_CHECK: begin
                    if (cnt == CW'(NCHK - 1)) begin
                        cur_len   <= new_cur_len;
                        cur_start <= new_cur_start;
                        // Strictly wider only: the earliest of equal windows is kept.
                        if (new_cur_len > best_len) begin
                            best_len   <= new_cur_len;
                            best_start <= new_cur_start;
                        end
                        cnt   <= '0;
                        state <= (tap == TW'(MAXTAP)) ? S_CENTRE : S_STEP;
                    end else begin
                        chk_ok <= good_now;
                        cnt    <= cnt + CW'(1);
                    end
                end

                // One increment, then hold off INC_GAP cycles before settling.
                S_STEP: begin
                    if (cnt == '0) begin
                        DINC <= lane_bit;
                        tap  <= tap + TW'(1);
                    end
                    if (cnt == CW'(INC_GAP - 1)) begin
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Reset the delay either way; only a wide enough eye gets a seek target.
                S_CENTRE: begin
                    DRST <= lane_bit;
                    tap  <= '0;
                    cnt  <= '0;
                    if (best_len < TW'(MINWIN)) begin
                        LOCKED[CUR_LANE] <= 1'b0;
                        state            <= S_NEXT;
                    end else begin
                        target <= best_start + (best_len >> 1);
                        state  <= S_SEEK;
                    end
                end

                // Walk the delay up to the eye centre; tap tracks the real delay so it never passes target.
                S_SEEK: begin
                    if ((cnt == '0) && (tap == target)) begin
                        slip  <= '0;
                        state <= S_SLIP_SETTLE;
                    end else begin
                        if (cnt == '0) begin
                            DINC <= lane_bit;
                            tap  <= tap + TW'(1);
                        end
                        cnt <= (cnt == CW'(INC_GAP - 1)) ? '0 : (cnt + CW'(1));
                    end
                end

                S_SLIP_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        chk_ok <= 1'b1;
                        cnt    <= '0;
                        state  <= S_SLIP_CHK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Word boundary check; W-1 slips cover every rotation before giving up.
                S_SLIP_CHK: begin
                    if (cnt == CW'(NCHK - 1)) begin
                        cnt <= '0;
                        if (pat_now) begin
                            LOCKED[CUR_LANE] <= 1'b1;
                            state            <= S_NEXT;
                        end else if (slip == SW'(W - 1)) begin
                            LOCKED[CUR_LANE] <= 1'b0;
                            state            <= S_NEXT;
                        end else begin
                            BS    <= lane_bit;
                            slip  <= slip + SW'(1);
                            state <= S_SLIP_SETTLE;
                        end
                    end else begin
                        chk_ok <= pat_now;
                        cnt    <= cnt + CW'(1);
                    end
                end

                S_NEXT: begin
                    if (CUR_LANE == LW'(NLANES - 1)) begin
                        state <= S_FINISH;
                    end else begin
                        CUR_LANE <= CUR_LANE + LW'(1);
                        state    <= S_LRST;
                    end
                end

                S_FINISH: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_lane_align.sv
// Directed bench for adc_lane_align with two lanes and a behavioural receiver model per lane.
// Each receiver tracks its delay tap (DRST/DINC) and slip count (BS) and emits a stable word inside its eye.
// Expected taps, slip counts and LOCKED values are hand-derived from the eye placement of each scenario.
module tb_adc_lane_align;

    localparam int NL     = 2;
    localparam int W      = 6;
    localparam int MAXTAP = 63;
    localparam logic [W-1:0] PAT = 6'b111000;

    logic              CLK;
    logic              RST_N;
    logic              START;
    logic [NL*W-1:0]   DIN;
    logic [NL-1:0]     DINC;
    logic [NL-1:0]     DRST;
    logic [NL-1:0]     BS;
    logic              BUSY;
    logic              DONE;
    logic [NL-1:0]     LOCKED;
    logic              CUR_LANE;

    adc_lane_align #(.NLANES(NL)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .DIN      (DIN),
        .DINC     (DINC),
        .DRST     (DRST),
        .BS       (BS),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .LOCKED   (LOCKED),
        .CUR_LANE (CUR_LANE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Receiver model state and eye description per lane.
    int           tap_m [NL];
    int           slip_m[NL];
    int           drst_n[NL];
    int           max_tap[NL];
    int           wa [NL];
    int           wb [NL];
    int           wa2[NL];
    int           wb2[NL];
    logic [W-1:0] base[NL];
    int           viol_onehot = 0;
    int           viol_width  = 0;
    int           viol_tap63  = 0;
    logic [NL-1:0] prev_dinc = '0;
    logic [NL-1:0] prev_drst = '0;
    logic [NL-1:0] prev_bs   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        r = x;
        for (int k = 0; k < n; k++) r = {r[0], r[W-1:1]};
        return r;
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        r = x;
        for (int k = 0; k < n; k++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    // Receivers react to the command pulses seen this cycle, then present the next lane words.
    initial begin
        DIN = '0;
        forever begin
            @(negedge CLK);
            if (($countones(DINC) + $countones(DRST) + $countones(BS)) > 1) viol_onehot++;
            if (((DINC | DRST | BS) != '0) && ((DINC | DRST | BS) != (NL'(1) << CUR_LANE))) viol_onehot++;
            if (((DINC & prev_dinc) | (DRST & prev_drst) | (BS & prev_bs)) != '0) viol_width++;
            prev_dinc = DINC;
            prev_drst = DRST;
            prev_bs   = BS;
            for (int i = 0; i < NL; i++) begin
                logic [31:0]  rnd;
                logic [W-1:0] w;
                if (DRST[i]) begin
                    tap_m[i] = 0;
                    drst_n[i]++;
                end
                if (DINC[i]) begin
                    if (tap_m[i] >= MAXTAP) viol_tap63++;
                    tap_m[i]++;
                    if (tap_m[i] > max_tap[i]) max_tap[i] = tap_m[i];
                end
                if (BS[i]) slip_m[i]++;
                rnd = $urandom;
                if ((tap_m[i] >= wa[i] && tap_m[i] <= wb[i]) || (tap_m[i] >= wa2[i] && tap_m[i] <= wb2[i]))
                    w = rotr(base[i], slip_m[i] % W);
                else
                    w = rnd[W-1:0];
                DIN[i*W +: W] = w;
            end
        end
    end

    task automatic set_lane(input int i, input int a, input int b, input int a2, input int b2,
                            input logic [W-1:0] word);
        wa[i]   = a;
        wb[i]   = b;
        wa2[i]  = a2;
        wb2[i]  = b2;
        base[i] = word;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            tap_m[i]   = 0;
            slip_m[i]  = 0;
            drst_n[i]  = 0;
            max_tap[i] = 0;
        end
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic seek_seen;
        RST_N = 1'b0;
        START = 1'b0;
        for (int i = 0; i < NL; i++) set_lane(i, -1, -1, -1, -1, PAT);
        clear_model();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outs", 32'({DINC, DRST, BS, BUSY, DONE, LOCKED, CUR_LANE}), 32'd0);
        RST_N = 1'b1;

        // Lane0 eye 10..30 (21 taps): centre 10+10=20, word needs 2 slips. Lane1 eye 5..12: 5+(8>>1)=9.
        set_lane(0, 10, 30, -1, -1, rotl(PAT, 2));
        set_lane(1, 5, 12, -1, -1, PAT);
        clear_model();
        pulse_start();
        wait_done("t1");
        chk("t1_locked", 32'(LOCKED), 32'd3);
        chk("t1_tap0", 32'(tap_m[0]), 32'd20);
        chk("t1_tap1", 32'(tap_m[1]), 32'd9);
        chk("t1_bs0", 32'(slip_m[0]), 32'd2);
        chk("t1_bs1", 32'(slip_m[1]), 32'd0);
        chk("t1_cur_lane", 32'(CUR_LANE), 32'd1);

        // Two 6-tap eyes: the first (3..8) wins, centre 3+3=6.
        set_lane(0, 3, 8, 20, 25, PAT);
        clear_model();
        pulse_start();
        wait_done("t2");
        chk("t2_tap0", 32'(tap_m[0]), 32'd6);
        chk("t2_locked", 32'(LOCKED), 32'd3);

        // 3-tap eye is too narrow: delay reset, no seek, no slip, lane1 still trained.
        set_lane(0, 20, 22, -1, -1, PAT);
        clear_model();
        pulse_start();
        wait_done("t3");
        chk("t3_locked", 32'(LOCKED), 32'd2);
        chk("t3_drst0", 32'(drst_n[0]), 32'd2);
        chk("t3_tap0", 32'(tap_m[0]), 32'd0);
        chk("t3_bs0", 32'(slip_m[0]), 32'd0);
        chk("t3_tap1", 32'(tap_m[1]), 32'd9);

        // Stable everywhere (eye 0..63, centre 32) but no rotation matches: five slips then give up.
        set_lane(0, 0, 63, -1, -1, 6'b101010);
        clear_model();
        pulse_start();
        wait_done("t4");
        chk("t4_bs0", 32'(slip_m[0]), 32'd5);
        chk("t4_locked", 32'(LOCKED), 32'd2);
        chk("t4_tap0", 32'(tap_m[0]), 32'd32);

        // Reset in the middle of lane0's seek, then retrain with a spurious START while busy.
        set_lane(0, 10, 30, -1, -1, PAT);
        clear_model();
        pulse_start();
        seek_seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge CLK); #1;
            if (drst_n[0] == 2 && tap_m[0] >= 5) begin
                seek_seen = 1'b1;
                break;
            end
        end
        chk("t5_seek_reached", 32'(seek_seen), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t5_async_reset", 32'({DINC, DRST, BS, BUSY, DONE, LOCKED, CUR_LANE}), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        clear_model();
        pulse_start();
        repeat (10) @(posedge CLK);
        chk("t5_busy", 32'(BUSY), 32'd1);
        pulse_start();
        wait_done("t5");
        chk("t5_drst0", 32'(drst_n[0]), 32'd2);
        chk("t5_drst1", 32'(drst_n[1]), 32'd2);
        chk("t5_locked", 32'(LOCKED), 32'd3);
        chk("t5_tap0", 32'(tap_m[0]), 32'd20);

        // Eye at the top of the range 60..63: centre 60+2=62, scan never steps past tap 63.
        set_lane(0, 60, 63, -1, -1, PAT);
        clear_model();
        pulse_start();
        wait_done("t6");
        chk("t6_tap0", 32'(tap_m[0]), 32'd62);
        chk("t6_max_tap0", 32'(max_tap[0]), 32'd63);
        chk("t6_dinc_at_63", 32'(viol_tap63), 32'd0);
        chk("t6_locked", 32'(LOCKED), 32'd3);

        chk("pulse_onehot", 32'(viol_onehot), 32'd0);
        chk("pulse_width", 32'(viol_width), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
